// File: rtl/alu_sequencer.sv
// Multicycle control FSM for the shared ALU: steps each instruction through its states and
// decodes ALU selects, strobes and memory handshake. Optional trap: ALU_SEQ_ILLEGAL_TRAP_EN.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] ALU_src1_sel,
    output logic [1:0] ALU_src2_sel,
    output logic [3:0] ALU_ctrl,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       IR_we,
    output logic       PC_we,
    output logic       reg_we,
    output logic [1:0] result_sel,
    output logic       rs1_zero,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [3:0] RESET_STATE = 4'd0;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSltu = 4'd6;
    localparam logic [3:0] AluSll  = 4'd7;
    localparam logic [3:0] AluSrl  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd9;

    typedef enum logic [3:0] {
        StFetch    = RESET_STATE,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StLui      = 4'd8,
        StAluWb    = 4'd9,
        StBranch   = 4'd10,
        StJalr     = 4'd11,
        StJal      = 4'd12,
        StIllegal  = 4'd13
    } state_e;

    state_e state_q, state_d;
    logic   taken;

    // SUB only exists in the register form; SRA/SRL split by funct7b5 in both forms.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5,
                                          input logic reg_form);
        logic [3:0] op;
        unique case (f3)
            3'b000:  op = (reg_form && f7b5) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = f7b5 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StFetch;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        taken        = 1'b0;
        ALU_src1_sel = 2'd0;
        ALU_src2_sel = 2'd0;
        ALU_ctrl     = AluAdd;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        IR_we        = 1'b0;
        PC_we        = 1'b0;
        reg_we       = 1'b0;
        result_sel   = 2'd0;
        rs1_zero     = 1'b0;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req      = 1'b1;
                ALU_src2_sel = 2'd2;
                if (mem_ready) begin
                    IR_we   = 1'b1;
                    PC_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ALU_src1_sel = 2'd1;
                ALU_src2_sel = 2'd1;
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = StMemAdr;
                    7'b0110011:             state_d = StExecR;
                    7'b0010011:             state_d = StExecI;
                    7'b0110111:             state_d = StLui;
                    7'b0010111:             state_d = StAluWb;
                    7'b1100011:             state_d = StBranch;
                    7'b1101111:             state_d = StJal;
                    7'b1100111:             state_d = StJalr;
                    default:                state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                ALU_src1_sel = 2'd2;
                ALU_src2_sel = 2'd1;
                state_d      = opcode[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_we     = 1'b1;
                result_sel = 2'd2;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExecR: begin
                ALU_src1_sel = 2'd2;
                ALU_ctrl     = alu_op(funct3, funct7b5, 1'b1);
                state_d      = StAluWb;
            end
            StExecI: begin
                ALU_src1_sel = 2'd2;
                ALU_src2_sel = 2'd1;
                ALU_ctrl     = alu_op(funct3, funct7b5, 1'b0);
                state_d      = StAluWb;
            end
            StLui: begin
                rs1_zero     = 1'b1;
                ALU_src1_sel = 2'd2;
                ALU_src2_sel = 2'd1;
                state_d      = StAluWb;
            end
            StAluWb: begin
                reg_we     = 1'b1;
                result_sel = 2'd1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                ALU_src1_sel = 2'd2;
                instr_done   = 1'b1;
                state_d      = StFetch;
                case (funct3)
                    3'b000: begin ALU_ctrl = AluSub;  taken = zero;  end
                    3'b001: begin ALU_ctrl = AluSub;  taken = !zero; end
                    3'b100: begin ALU_ctrl = AluSlt;  taken = !zero; end
                    3'b101: begin ALU_ctrl = AluSlt;  taken = zero;  end
                    3'b110: begin ALU_ctrl = AluSltu; taken = !zero; end
                    3'b111: begin ALU_ctrl = AluSltu; taken = zero;  end
                    default: begin
                        instr_done = 1'b0;
                        state_d    = StIllegal;
                    end
                endcase
                if (taken) begin
                    PC_we      = 1'b1;
                    result_sel = 2'd1;
                end
            end
            StJalr: begin
                ALU_src1_sel = 2'd2;
                ALU_src2_sel = 2'd1;
                state_d      = StJal;
            end
            StJal: begin
                PC_we        = 1'b1;
                result_sel   = 2'd1;
                ALU_src1_sel = 2'd1;
                ALU_src2_sel = 2'd2;
                state_d      = StAluWb;
            end
            StIllegal: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                illegal = 1'b1;
                state_d = StIllegal;
`else
                instr_done = 1'b1;
                state_d    = StFetch;
`endif
            end
            default: state_d = StFetch;
        endcase
        // Outputs are combinational, so reset must mask them (FETCH would otherwise request).
        if (!rst_n) begin
            ALU_src1_sel = 2'd0;
            ALU_src2_sel = 2'd0;
            ALU_ctrl     = AluAdd;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            addr_sel     = 1'b0;
            IR_we        = 1'b0;
            PC_we        = 1'b0;
            reg_we       = 1'b0;
            result_sel   = 2'd0;
            rs1_zero     = 1'b0;
            instr_done   = 1'b0;
            illegal      = 1'b0;
        end
    end

endmodule
